// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter: SW-stage pipelined barrel shifter (lsr/asr/lsl/ror), largest shift first,
// with a valid/ready handshake on both sides.
module pipe_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  logic [SW-1:0] w_v;
  logic [SW-1:0] w_ld;
  for (genvar k = 0; k < SW; k++) begin : g_st
    localparam int SH = 1 << (SW - 1 - k);
    logic             w_vin;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_ars;
    logic [WIDTH-1:0] w_res;
    logic [SW-k-1:0]  w_ai;
    logic [1:0]       w_mi;
    logic             r_v;
    logic [WIDTH-1:0] r_d;
    if (k == 0) begin : g_i
      assign w_vin = in_valid;
      assign w_src = in_data;
      assign w_ai  = in_amt;
      assign w_mi  = in_mode;
    end else begin : g_i
      assign w_vin = g_st[k-1].r_v;
      assign w_src = g_st[k-1].r_d;
      assign w_ai  = g_st[k-1].g_c.r_a;
      assign w_mi  = g_st[k-1].g_c.r_m;
    end
    // a stage loads unless it and every stage after it hold data that cannot drain
    assign w_ld[k] = out_ready || !(&w_v[SW-1:k]);
    assign w_v[k]  = r_v;
    assign w_ars   = $signed(w_src) >>> SH;
    always_comb
      w_res = !w_ai[SW-k-1] ? w_src :
              w_mi == 2'b00 ? w_src >> SH :
              w_mi == 2'b01 ? w_ars :
              w_mi == 2'b10 ? w_src << SH :
              (w_src >> SH) | (w_src << (WIDTH - SH));
    always_ff @(posedge clk)
      if (!rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (w_ld[k]) begin
        r_v <= w_vin;
        r_d <= w_res;
      end
    if (k < SW - 1) begin : g_c
      // only the amount bits still to be applied travel on
      logic [SW-k-2:0] r_a;
      logic [1:0]      r_m;
      always_ff @(posedge clk)
        if (!rst_n) begin
          r_a <= '0;
          r_m <= '0;
        end else if (w_ld[k]) begin
          r_a <= w_ai[SW-k-2:0];
          r_m <= w_mi;
        end
    end else begin : g_o
      logic r_z;
      always_ff @(posedge clk)
        if (!rst_n) r_z <= 1'b0;
        else if (w_ld[k]) r_z <= ~|w_res;
      assign out_valid = r_v;
      assign out_data  = r_d;
      assign out_zero  = r_z;
    end
  end
  assign in_ready = w_ld[0];
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter: scoreboard bench for pipe_barrel_shifter at WIDTH=8, 16 and 32.
module tb_pipe_barrel_shifter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [2:0]       rst_n, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [2:0][31:0] in_data, out_data;
  logic [2:0][4:0]  in_amt;
  logic [2:0][1:0]  in_mode;

  logic [32:0] q[3][$];
  int          n_in[3];
  int          n_out[3];
  logic [2:0]  stall;
  logic [31:0] hold[3];

  localparam logic [31:0] MODE_E[4] = '{32'h16, 32'hF6, 32'hA0, 32'h96};
  localparam logic [31:0] BP_D[5]   = '{32'hF0, 32'hF0, 32'h0F, 32'h81, 32'h3C};
  localparam logic [4:0]  BP_A[5]   = '{5'd4, 5'd4, 5'd4, 5'd1, 5'd2};
  localparam logic [1:0]  BP_M[5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic [31:0] BP_E[5]   = '{32'h0F, 32'hFF, 32'hF0, 32'hC0, 32'h0F};

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int W = 8 << i;
    localparam int S = $clog2(W);
    logic [W-1:0] w_od;
    pipe_barrel_shifter #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[i]),
      .in_valid (in_valid[i]),
      .in_ready (in_ready[i]),
      .in_data  (in_data[i][W-1:0]),
      .in_amt   (in_amt[i][S-1:0]),
      .in_mode  (in_mode[i]),
      .out_valid(out_valid[i]),
      .out_ready(out_ready[i]),
      .out_data (w_od),
      .out_zero (out_zero[i])
    );
    assign out_data[i] = 32'(w_od);
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                        input logic [1:0] m, input int w);
    logic [63:0] mk, x, r;
    mk = (64'd1 << w) - 64'd1;
    x  = {32'b0, d} & mk;
    case (m)
      2'b00:   r = x >> a;
      2'b01:   r = (x >> a) | (x[w-1] ? mk & ~(mk >> a) : 64'd0);
      2'b10:   r = (x << a) & mk;
      default: r = ((x >> a) | (x << (w - int'(a)))) & mk;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (WIDTH=%0d): got 0x%0h, expected 0x%0h", nm, 8 << i, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                      input logic [32:0] e, input bit use_model, output int waits);
    logic [31:0] mv;
    waits = 0;
    in_data[i]  = d;
    in_amt[i]   = a;
    in_mode[i]  = m;
    in_valid[i] = 1'b1;
    mv = model(in_data[i], in_amt[i], in_mode[i], 8 << i);
    if (use_model) e = {~|mv, mv};
    @(negedge clk);
    while (!in_ready[i] && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready[i]) chk("accept timeout", i, 64'(in_ready[i]), 64'd1);
    @(posedge clk);
    #1;
    q[i].push_back(e);
    n_in[i]++;
    in_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int t = 0;
    while (q[i].size() != 0 && t < 300) begin
      t++;
      @(posedge clk);
    end
    if (q[i].size() != 0) chk("drain timeout", i, 64'(q[i].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int i);
    bit done = 1'b0;
    int w;
    fork
      begin
        for (int j = 0; j < 10000; j++) begin
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
          send(i, $urandom, 5'($urandom_range(0, (8 << i) - 1)), 2'($urandom_range(0, 3)),
               33'd0, 1'b1, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready[i] = ($urandom_range(0, 3) != 0);
        end
        out_ready[i] = 1'b1;
      end
    join
  endtask

  initial begin
    logic [32:0] e;
    stall = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n[i]) begin
          q[i].delete();
          stall[i] = 1'b0;
        end else begin
          if (stall[i]) begin
            chk("hold out_valid", i, 64'(out_valid[i]), 64'd1);
            chk("hold out_data", i, 64'(out_data[i]), 64'(hold[i]));
          end
          if (out_valid[i] && out_ready[i]) begin
            if (q[i].size() == 0) chk("unexpected output", i, 64'(out_valid[i]), 64'd0);
            else begin
              e = q[i].pop_front();
              n_out[i]++;
              chk("out_data", i, 64'(out_data[i]), 64'(e[31:0]));
              chk("out_zero", i, 64'(out_zero[i]), 64'(e[32]));
            end
          end
          stall[i] = out_valid[i] && !out_ready[i];
          hold[i]  = out_data[i];
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, tw, c, base;
    int bi[3], bo[3];
    rst_n     = '0;
    in_valid  = 3'b111;
    out_ready = 3'b111;
    in_data   = {3{32'h5A}};
    in_amt    = '0;
    in_mode   = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset out_valid", i, 64'(out_valid[i]), 64'd0);
      chk("reset out_data", i, 64'(out_data[i]), 64'd0);
      chk("reset out_zero", i, 64'(out_zero[i]), 64'd0);
      chk("reset in_ready", i, 64'(in_ready[i]), 64'd1);
    end
    rst_n    = 3'b111;
    in_valid = '0;
    @(posedge clk);
    #1;

    for (int m = 0; m < 4; m++) begin
      send(0, 32'hB4, 5'd3, 2'(m), {1'b0, MODE_E[m]}, 1'b0, w);
      @(posedge clk);
      #1;
      chk("latency early", 0, 64'(out_valid[0]), 64'd0);
      @(posedge clk);
      #1;
      chk("latency", 0, 64'(out_valid[0]), 64'd1);
      @(posedge clk);
      #1;
    end
    send(0, 32'h80, 5'd7, 2'd1, {1'b0, 32'hFF}, 1'b0, w);
    send(0, 32'h01, 5'd1, 2'd0, {1'b1, 32'h00}, 1'b0, w);
    for (int m = 0; m < 4; m++) send(0, 32'h5A, 5'd0, 2'(m), {1'b0, 32'h5A}, 1'b0, w);
    drain(0);

    fork
      begin
        tw = 0;
        for (int j = 0; j < 16; j++) begin
          send(0, 32'(j * 37 + 5), 5'(j % 8), 2'(j % 4), 33'd0, 1'b1, w);
          tw += w;
        end
        chk("throughput in_ready stalls", 0, 64'(tw), 64'd0);
      end
      begin
        c = 0;
        @(negedge clk);
        while (!out_valid[0] && c < 20) begin
          c++;
          @(negedge clk);
        end
        chk("throughput first output cycle", 0, 64'(c), 64'd3);
        c = 0;
        while (out_valid[0] && c < 40) begin
          c++;
          @(negedge clk);
        end
        chk("throughput run length", 0, 64'(c), 64'd16);
      end
    join
    drain(0);

    out_ready[0] = 1'b0;
    base = n_in[0];
    fork
      for (int j = 0; j < 5; j++) send(0, BP_D[j], BP_A[j], BP_M[j], {1'b0, BP_E[j]}, 1'b0, w);
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("backpressure accepted", 0, 64'(n_in[0] - base), 64'd3);
        chk("backpressure in_ready", 0, 64'(in_ready[0]), 64'd0);
        chk("backpressure out_valid", 0, 64'(out_valid[0]), 64'd1);
        chk("backpressure head", 0, 64'(out_data[0]), 64'h0F);
        out_ready[0] = 1'b1;
      end
    join
    drain(0);

    send(0, 32'h11, 5'd1, 2'd2, {1'b0, 32'h22}, 1'b0, w);
    send(0, 32'h33, 5'd1, 2'd0, {1'b0, 32'h19}, 1'b0, w);
    rst_n[0]    = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h77;
    @(posedge clk);
    #1;
    chk("midreset out_valid", 0, 64'(out_valid[0]), 64'd0);
    chk("midreset out_data", 0, 64'(out_data[0]), 64'd0);
    chk("midreset in_ready", 0, 64'(in_ready[0]), 64'd1);
    rst_n[0]    = 1'b1;
    in_valid[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midreset stale out_valid", 0, 64'(out_valid[0]), 64'd0);

    for (int i = 0; i < 3; i++) begin
      bi[i] = n_in[i];
      bo[i] = n_out[i];
    end
    fork
      rnd(0);
      rnd(1);
      rnd(2);
    join
    for (int i = 0; i < 3; i++) begin
      drain(i);
      chk("random transfer count", i, 64'(n_out[i] - bo[i]), 64'(n_in[i] - bi[i]));
      chk("random operand count", i, 64'(n_in[i] - bi[i]), 64'd10000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
